// File: rtl/aes_key_schedule_if.sv
// -----------------------------------------------------------------------------
// aes_key_schedule_if
// Bundles the request, status and round-key read signals of the AES key
// scheduler so the scheduler and its user connect through one port.
//   master : drives start/key_len/key and the read request (rd_en/rd_idx/rd_rev)
//   slave  : the scheduler; returns busy/ready/err/nr and rd_valid/rd_key
// -----------------------------------------------------------------------------
interface aes_key_schedule_if;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key;
   logic         busy;
   logic         ready;
   logic         err;
   logic [3:0]   nr;
   logic         rd_en;
   logic [3:0]   rd_idx;
   logic         rd_rev;
   logic         rd_valid;
   logic [127:0] rd_key;

   modport master (
      output start, key_len, key, rd_en, rd_idx, rd_rev,
      input  busy, ready, err, nr, rd_valid, rd_key
   );

   modport slave (
      input  start, key_len, key, rd_en, rd_idx, rd_rev,
      output busy, ready, err, nr, rd_valid, rd_key
   );
endinterface

// File: rtl/aes_key_schedule.sv
// -----------------------------------------------------------------------------
// aes_key_schedule
// Iterative AES-128/192/256 key expansion: the cipher key is loaded into a word
// store on an accepted start, then one 32-bit schedule word is produced per
// clock. Once complete, 128-bit round keys are served through a registered
// read port in forward or reverse round order.
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   ks.start         : one-cycle expansion request (key_len 00/01/10 = 128/192/256)
//   ks.key           : cipher key, MSB-first, w0 = key[255:224]
//   ks.busy/ready    : expansion running / schedule complete
//   ks.err           : one-cycle pulse for a rejected start
//   ks.nr            : round count of the stored schedule
//   ks.rd_en/idx/rev : round-key read request; rd_valid/rd_key one cycle later
// MAX_WORDS sets the store depth and must be at least 60.
// SUPPORT_256 = 0 makes key_len 10 a rejected request.
// Also contains aes_sbox, the byte substitution table used by SubWord.
// -----------------------------------------------------------------------------

// Combinational AES forward S-box for one byte.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign y = SBOX[a];
endmodule

module aes_key_schedule #(
   parameter int MAX_WORDS   = 60,
   parameter bit SUPPORT_256 = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   aes_key_schedule_if.slave  ks
);
   localparam int AW = $clog2(MAX_WORDS);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t         state_q, state_d;
   logic [1:0]     len_q;
   logic [AW-1:0]  i_q;        // index of the word written this cycle
   logic [2:0]     kmod_q;     // i_q mod Nk, kept as a wrapping counter
   logic [7:0]     rcon_q;
   logic           err_q;
   logic [3:0]     nr_q;
   logic           rd_valid_q;
   logic [127:0]   rd_key_q;
   logic [31:0]    w [MAX_WORDS];

   logic           key_len_ok, accept, reject, last_word;
   logic [31:0]    prev_word, back_word, sub_in, sub_out, temp, new_word;
   logic [3:0]     rd_r;
   logic [AW-1:0]  rd_base;
   logic           rd_ok;

   // ---- key-length decode ---------------------------------------------------
   function automatic logic [AW-1:0] nk_words(input logic [1:0] len);
      case (len)
         2'b00:   return AW'(4);
         2'b01:   return AW'(6);
         default: return AW'(8);
      endcase
   endfunction

   function automatic logic [2:0] last_kmod(input logic [1:0] len);
      case (len)
         2'b00:   return 3'd3;
         2'b01:   return 3'd5;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [AW-1:0] last_idx(input logic [1:0] len);
      case (len)
         2'b00:   return AW'(43);
         2'b01:   return AW'(51);
         default: return AW'(59);
      endcase
   endfunction

   function automatic logic [3:0] rounds(input logic [1:0] len);
      case (len)
         2'b00:   return 4'd10;
         2'b01:   return 4'd12;
         default: return 4'd14;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   assign key_len_ok = (ks.key_len == 2'b00) || (ks.key_len == 2'b01) ||
                       ((ks.key_len == 2'b10) && SUPPORT_256);

   // ---- FSM: next state and control strobes --------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      state_d   = state_q;
      accept    = 1'b0;
      reject    = 1'b0;
      last_word = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (ks.start) begin
               if (key_len_ok) begin
                  accept  = 1'b1;
                  state_d = EXPAND;
               end else begin
                  reject  = 1'b1;
               end
            end
         end
         EXPAND: begin
            reject = ks.start;
            if (i_q == last_idx(len_q)) begin
               last_word = 1'b1;
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- expansion datapath ---------------------------------------------------
   assign prev_word = w[i_q - AW'(1)];
   assign back_word = w[i_q - nk_words(len_q)];
   // RotWord only on the i mod Nk == 0 step; the 256-bit mid-key step substitutes unrotated.
   assign sub_in    = (kmod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
   end

   always_comb begin
      temp = prev_word;
      if (kmod_q == 3'd0)
         temp = sub_out ^ {rcon_q, 24'h0};
      else if ((len_q == 2'b10) && (kmod_q == 3'd4))
         temp = sub_out;
   end

   assign new_word = back_word ^ temp;

   // ---- word store -----------------------------------------------------------
   // NOTE: the store carries no reset; ready gates every read, so its power-up contents are never observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int j = 0; j < 8; j++)
            if (AW'(j) < nk_words(ks.key_len))
               w[j] <= ks.key[255-32*j -: 32];
      end else if (state_q == EXPAND) begin
         w[i_q] <= new_word;
      end
   end

   // ---- read address ---------------------------------------------------------
   assign rd_ok   = (state_q == DONE) && (ks.rd_idx <= nr_q);
   assign rd_r    = ks.rd_rev ? (nr_q - ks.rd_idx) : ks.rd_idx;
   assign rd_base = AW'({rd_r, 2'b00});

   // ---- control and read registers ---------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= 2'b00;
         i_q        <= '0;
         kmod_q     <= 3'd0;
         rcon_q     <= 8'h00;
         err_q      <= 1'b0;
         nr_q       <= 4'd0;
         rd_valid_q <= 1'b0;
         rd_key_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= reject;

         if (accept) begin
            len_q  <= ks.key_len;
            i_q    <= nk_words(ks.key_len);
            kmod_q <= 3'd0;
            rcon_q <= 8'h01;
         end else if (state_q == EXPAND) begin
            i_q    <= i_q + AW'(1);
            kmod_q <= (kmod_q == last_kmod(len_q)) ? 3'd0 : kmod_q + 3'd1;
            if (kmod_q == 3'd0)
               rcon_q <= xtime(rcon_q);
         end

         if (last_word)
            nr_q <= rounds(len_q);

         if (ks.rd_en) begin
            rd_valid_q <= rd_ok;
            rd_key_q   <= rd_ok ? {w[rd_base], w[rd_base + AW'(1)],
                                   w[rd_base + AW'(2)], w[rd_base + AW'(3)]} : '0;
         end else begin
            rd_valid_q <= 1'b0;
         end
      end
   end

   assign ks.busy     = (state_q == EXPAND);
   assign ks.ready    = (state_q == DONE);
   assign ks.err      = err_q;
   assign ks.nr       = nr_q;
   assign ks.rd_valid = rd_valid_q;
   assign ks.rd_key   = rd_key_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_aes_key_schedule
// Directed test of aes_key_schedule against the FIPS-197 key expansion vectors
// for AES-128/192/256, plus error, read-port and asynchronous-reset behaviour.
// -----------------------------------------------------------------------------
module tb_aes_key_schedule;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n;
   int   err_seen;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffff0000_12345678};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
   localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
   localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   aes_key_schedule_if ks ();

   aes_key_schedule #(.MAX_WORDS(60), .SUPPORT_256(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ks    (ks)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a start and count edges after the start edge until ready is seen.
   task automatic run_start(input logic [1:0] len, input logic [255:0] key, input int exp_lat, input string tag);
      int cnt;
      ks.start   = 1'b1;
      ks.key_len = len;
      ks.key     = key;
      tick();
      ks.start = 1'b0;
      check({tag, "_busy"}, ks.busy, 1);
      cnt = 0;
      while (!ks.ready && cnt < 200) begin
         tick();
         cnt++;
      end
      check({tag, "_latency"}, cnt, exp_lat);
   endtask

   task automatic do_read(input logic [3:0] idx, input logic rev);
      ks.rd_en  = 1'b1;
      ks.rd_idx = idx;
      ks.rd_rev = rev;
      tick();
      ks.rd_en  = 1'b0;
   endtask

   initial begin
      ks.start   = 1'b0;
      ks.key_len = 2'b00;
      ks.key     = '0;
      ks.rd_en   = 1'b0;
      ks.rd_idx  = 4'd0;
      ks.rd_rev  = 1'b0;
      tick();
      check("reset_outputs", {ks.busy, ks.ready, ks.err, ks.nr, ks.rd_valid, ks.rd_key}, 0);
      rst_n = 1'b1;
      tick();

      // AES-128
      run_start(2'b00, K128, 40, "aes128");
      check("aes128_nr", ks.nr, 10);
      do_read(4'd10, 1'b0);
      check("aes128_r10_valid", ks.rd_valid, 1);
      check("aes128_r10", ks.rd_key, R128_10);
      do_read(4'd0, 1'b1);
      check("aes128_rev0", ks.rd_key, R128_10);

      // Back-to-back reads with rd_en held
      ks.rd_en  = 1'b1;
      ks.rd_rev = 1'b0;
      for (int k = 0; k < 16; k++) begin
         ks.rd_idx = 4'(k);
         tick();
         check($sformatf("seq_valid_%0d", k), ks.rd_valid, (k <= 10) ? 1 : 0);
         if (k > 10) check($sformatf("seq_zero_%0d", k), ks.rd_key, 0);
         if (k == 0) check("seq_r0", ks.rd_key, R128_0);
         if (k == 1) check("seq_r1", ks.rd_key, R128_1);
         if (k == 10) check("seq_r10", ks.rd_key, R128_10);
      end
      ks.rd_en = 1'b0;

      // rd_en low holds rd_key
      do_read(4'd1, 1'b0);
      tick();
      check("hold_valid", ks.rd_valid, 0);
      check("hold_key", ks.rd_key, R128_1);

      // Invalid key_len in DONE
      ks.start   = 1'b1;
      ks.key_len = 2'b11;
      tick();
      ks.start = 1'b0;
      check("badlen_err", ks.err, 1);
      check("badlen_ready", ks.ready, 1);
      tick();
      check("badlen_err_pulse", ks.err, 0);
      do_read(4'd10, 1'b0);
      check("badlen_keep_r10", ks.rd_key, R128_10);

      // AES-192
      run_start(2'b01, K192, 46, "aes192");
      check("aes192_nr", ks.nr, 12);
      do_read(4'd12, 1'b0);
      check("aes192_r12", ks.rd_key, R192_12);
      do_read(4'd12, 1'b1);
      check("aes192_rev12", ks.rd_key, R192_0);

      // AES-256
      run_start(2'b10, K256, 52, "aes256");
      check("aes256_nr", ks.nr, 14);
      do_read(4'd14, 1'b0);
      check("aes256_r14", ks.rd_key, R256_14);
      do_read(4'd0, 1'b0);
      check("aes256_r0", ks.rd_key, R256_0);

      // Restart from DONE with a second start mid-expansion
      ks.start   = 1'b1;
      ks.key_len = 2'b00;
      ks.key     = K128;
      tick();
      ks.start = 1'b0;
      check("restart_ready_drop", ks.ready, 0);
      n = 0;
      err_seen = 0;
      while (!ks.ready && n < 200) begin
         if (n == 5) begin
            ks.start   = 1'b1;
            ks.key_len = 2'b01;
            ks.key     = K192;
         end else begin
            ks.start = 1'b0;
         end
         tick();
         n++;
         if (ks.err) err_seen++;
      end
      ks.start = 1'b0;
      check("midstart_latency", n, 40);
      check("midstart_err_count", err_seen, 1);
      check("midstart_nr", ks.nr, 10);
      do_read(4'd10, 1'b0);
      check("midstart_r10", ks.rd_key, R128_10);

      // Asynchronous reset during AES-256 expansion
      ks.start   = 1'b1;
      ks.key_len = 2'b10;
      ks.key     = K256;
      tick();
      ks.start = 1'b0;
      repeat (19) tick();
      check("pre_reset_busy", ks.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {ks.busy, ks.ready, ks.err, ks.nr, ks.rd_valid, ks.rd_key}, 0);
      #2 rst_n = 1'b1;
      repeat (3) tick();
      check("post_reset_idle", {ks.busy, ks.ready}, 0);

      run_start(2'b10, K256, 52, "aes256_again");
      check("aes256_again_nr", ks.nr, 14);
      do_read(4'd14, 1'b0);
      check("aes256_again_r14", ks.rd_key, R256_14);
      do_read(4'd14, 1'b1);
      check("aes256_again_rev14", ks.rd_key, R256_0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
